// File: rtl/sample_feed_tx.sv
// sample_feed_tx
//   Streams 3-bit GPS samples from an internal FIFO to a consumer. The consumer
//   gets a sample clock (clk_sample) derived from clk, a sample-counter reset
//   (feed_reset) and a completion flag. A feed is a fixed number of samples,
//   preceded by RESET_PERIODS sample-clock periods with feed_reset high.
//
//   Optional feature macro: SAMPLE_FEED_STALL_EN
//     defined   : an empty FIFO at the start of a sample period freezes the
//                 sample clock low until data arrives.
//     undefined : the period runs anyway and the previous sample repeats.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   wr_en, wr_data, full  FIFO write side
//   start, abort, length  feed control (length latched on an accepted start)
//   clk_sample, data      consumer sample clock and sample
//   feed_reset            consumer sample-counter reset
//   feed_complete, busy   feed status
//   overflow, underflow   sticky error flags, cleared by an accepted start
module sample_feed_tx #(
  parameter int HALF_PERIOD   = 6,
  parameter int RESET_PERIODS = 4,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_data,
  output logic        full,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] length,
  output logic        clk_sample,
  output logic [2:0]  data,
  output logic        feed_reset,
  output logic        feed_complete,
  output logic        busy,
  output logic        overflow,
  output logic        underflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int PW  = $clog2(2 * HALF_PERIOD);
  localparam int RW  = (RESET_PERIODS > 1) ? $clog2(RESET_PERIODS) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0]  PH_HIGH = PW'(HALF_PERIOD);
  localparam logic [RW-1:0]  RP_LAST = RW'(RESET_PERIODS - 1);
  localparam logic [AW1-1:0] DEPTH   = AW1'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_phase, w_phase_nxt;
  logic [RW-1:0]  r_rcnt, w_rcnt_nxt;
  logic [15:0]    r_remain;
  logic [2:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW1-1:0] r_count, w_count_nxt;
  logic           r_full;
  logic [2:0]     r_data, w_data_nxt;
  logic           r_clk_sample, r_feed_reset, r_feed_complete, r_busy;
  logic           r_overflow, r_underflow;
  logic           w_clk_nxt, w_freset_nxt, w_fdone_nxt, w_busy_nxt;
  logic           w_start_ok, w_slot, w_pop, w_dec, w_unf_set;
  logic           w_push, w_ovf_set, w_empty;
`ifdef SAMPLE_FEED_STALL_EN
  logic           r_stall, w_stall_nxt;
`endif

  assign w_empty   = (r_count == '0);
  // A write while full only gets in if a pop frees the slot in the same cycle.
  assign w_push    = wr_en & ~abort & (~r_full | w_pop);
  assign w_ovf_set = wr_en & ~abort & r_full & ~w_pop;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and period sequencing; w_slot marks the edge into phase 0 of a RUN period
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_rcnt_nxt  = r_rcnt;
    w_slot      = 1'b0;
    w_start_ok  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_phase_nxt = '0;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_RESET;
            w_phase_nxt = '0;
            w_rcnt_nxt  = '0;
            w_start_ok  = 1'b1;
          end else begin
            w_phase_nxt = '0;
          end
        end
        S_RESET: begin
          if (r_phase == PH_LAST) begin
            w_phase_nxt = '0;
            if (r_rcnt == RP_LAST) begin
              if (r_remain != 16'd0) begin
                w_state_nxt = S_RUN;
                w_slot      = 1'b1;
              end else begin
                w_state_nxt = S_DONE;
              end
            end else begin
              w_rcnt_nxt = r_rcnt + RW'(1);
            end
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
        S_RUN: begin
`ifdef SAMPLE_FEED_STALL_EN
          if (r_stall) begin
            w_phase_nxt = r_phase;
          end else
`endif
          if (r_phase == PH_LAST) begin
            w_phase_nxt = '0;
            // remain reaches zero on the last pop, so this period carried it
            if (r_remain == 16'd0) w_state_nxt = S_DONE;
            else                   w_slot      = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
        end
      endcase
    end
  end

  // Pop / decrement / underflow decision at each sample slot
  always_comb begin
    w_pop     = 1'b0;
    w_dec     = 1'b0;
    w_unf_set = 1'b0;
`ifdef SAMPLE_FEED_STALL_EN
    w_stall_nxt = r_stall;
    if (abort) begin
      w_stall_nxt = 1'b0;
    end else if (w_slot) begin
      if (!w_empty) begin
        w_pop = 1'b1;
        w_dec = 1'b1;
      end else begin
        w_stall_nxt = 1'b1;
        w_unf_set   = 1'b1;
      end
    end else if (r_stall && !w_empty) begin
      // data arrived: load it and restart phase 0 so it gets a full low half
      w_pop       = 1'b1;
      w_dec       = 1'b1;
      w_stall_nxt = 1'b0;
    end else begin
      w_stall_nxt = r_stall;
    end
`else
    if (w_slot) begin
      w_dec     = 1'b1;
      w_pop     = ~w_empty;
      w_unf_set = w_empty;
    end else begin
      w_dec = 1'b0;
    end
`endif
  end

  // Next values of the registered outputs, decoded from the next state/phase
  always_comb begin
    w_busy_nxt   = (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
    w_clk_nxt    = w_busy_nxt && (w_phase_nxt >= PH_HIGH);
    w_freset_nxt = (w_state_nxt == S_RESET);
    w_fdone_nxt  = (w_state_nxt == S_DONE);
    if (abort || w_start_ok) w_data_nxt = 3'd0;
    else if (w_pop)          w_data_nxt = r_mem[r_rptr];
    else                     w_data_nxt = r_data;
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    if (w_push && !w_pop)      w_count_nxt = r_count + AW1'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - AW1'(1);
    else                       w_count_nxt = r_count;
  end

  // FIFO storage write port (array contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  // FIFO pointers, count and registered full flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH);
    end
  end

  // Feed counters, sample register and sticky flags (a new error beats the start clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= '0;
      r_rcnt      <= '0;
      r_remain    <= 16'd0;
      r_data      <= 3'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
`ifdef SAMPLE_FEED_STALL_EN
      r_stall     <= 1'b0;
`endif
    end else begin
      r_phase <= w_phase_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_data  <= w_data_nxt;
      if (w_start_ok) r_remain <= length;
      else if (w_dec) r_remain <= r_remain - 16'd1;
      r_overflow  <= w_ovf_set | (r_overflow & ~w_start_ok);
      r_underflow <= w_unf_set | (r_underflow & ~w_start_ok);
`ifdef SAMPLE_FEED_STALL_EN
      r_stall     <= w_stall_nxt;
`endif
    end
  end

  // Registered consumer-facing control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sample    <= 1'b0;
      r_feed_reset    <= 1'b0;
      r_feed_complete <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_clk_sample    <= w_clk_nxt;
      r_feed_reset    <= w_freset_nxt;
      r_feed_complete <= w_fdone_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  assign full          = r_full;
  assign clk_sample    = r_clk_sample;
  assign data          = r_data;
  assign feed_reset    = r_feed_reset;
  assign feed_complete = r_feed_complete;
  assign busy          = r_busy;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
